// File: rtl/rom_loader_arb_pkg.sv
// Shared types and framing constants for the boot-time ROM loader.
package lib_loader;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      RUN,
      ERR
   } loader_state_t;

   localparam logic [7:0] LOAD_MAGIC = 8'hA5;
   localparam logic [7:0] SKIP_MAGIC = 8'h5A;

endpackage : lib_loader

// File: rtl/rom_loader_arb_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses the
// cycle after the fourth byte, while word still holds the completed value.
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0] idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else if (clear) begin
         idx        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= byte_valid && (idx == 2'd3);
         if (byte_valid) begin
            // Shift right so the first byte ends up in bits [7:0].
            word <= {byte_in, word[31:8]};
            idx  <= idx + 2'd1;
         end
      end
   end

endmodule : byte_packer

// File: rtl/rom_loader_arb.sv
// Boot loader / ROM port arbiter: loads a UART-framed program into the
// instruction ROM, then releases the CPU. Optional checksum: LOADER_CHECKSUM_EN.
module rom_loader_arb
   import lib_loader::*;
#(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   input  logic [ADDR_W-1:0] cpu_rom_addr,
   output logic [31:0]       cpu_rom_data,
   output logic              cpu_reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic              rom_we,
   output logic [31:0]       rom_wdata,
   output logic              loading,
   output logic              load_done,
   output logic              err
);

   localparam int unsigned CNT_W     = 17;
   localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned ROM_WORDS = 2 ** ADDR_W;

   loader_state_t    state, state_nxt;
   logic [7:0]       len_lo;
   logic [15:0]      n_words;
   logic [CNT_W-1:0] wr_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   logic        cpu_reset_nxt, loading_nxt, load_done_nxt, err_nxt;
   logic        frame_start_c, abort_c, in_frame_c, tmo_hit_c, last_word_c, data_byte_c;
   logic [15:0] len_c;
   logic [31:0] pk_word;
   logic        pk_valid;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   assign len_c       = {rx_byte, len_lo};
   assign data_byte_c = rx_valid && (state == DATA);
   assign tmo_hit_c   = (tmo_cnt == TMO_W'(TIMEOUT_CYC));
   assign last_word_c = pk_valid && ((wr_cnt + CNT_W'(1)) == CNT_W'(n_words));
`ifdef LOADER_CHECKSUM_EN
   assign in_frame_c  = (state inside {LEN_LO, LEN_HI, DATA, CSUM});
`else
   assign in_frame_c  = (state inside {LEN_LO, LEN_HI, DATA});
`endif

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (frame_start_c || abort_c),
      .byte_valid (data_byte_c),
      .byte_in    (rx_byte),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_nxt     = state;
      frame_start_c = 1'b0;
      abort_c       = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_valid && (rx_byte == LOAD_MAGIC)) begin
               state_nxt     = LEN_LO;
               frame_start_c = 1'b1;
            end else if (rx_valid && (rx_byte == SKIP_MAGIC)) begin
               state_nxt = DONE;
            end
         end
         LEN_LO: if (rx_valid) state_nxt = LEN_HI;
         LEN_HI: begin
            if (rx_valid) begin
               if (len_c == 16'd0)                  state_nxt = DONE;
               else if (32'(len_c) > ROM_WORDS)     state_nxt = ERR;
               else                                 state_nxt = DATA;
            end
         end
         DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (last_word_c) state_nxt = CSUM;
`else
            if (last_word_c) state_nxt = DONE;
`endif
         end
         CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (rx_valid) state_nxt = (rx_byte == csum) ? DONE : ERR;
`else
            state_nxt = IDLE;
`endif
         end
         DONE: state_nxt = RUN;
         RUN:  state_nxt = RUN;
         ERR: begin
            if (rx_valid && (rx_byte == LOAD_MAGIC)) begin
               state_nxt     = LEN_LO;
               frame_start_c = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // An arriving byte always beats an expiring timeout.
      if (in_frame_c && tmo_hit_c && !rx_valid) begin
         state_nxt = IDLE;
         abort_c   = 1'b1;
      end

      cpu_reset_nxt = !(state_nxt inside {DONE, RUN});
      loading_nxt   = (state_nxt inside {LEN_LO, LEN_HI, DATA});
      load_done_nxt = (state_nxt == DONE);
      err_nxt       = (state_nxt == ERR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cpu_reset <= 1'b1;
         loading   <= 1'b0;
         load_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cpu_reset <= cpu_reset_nxt;
         loading   <= loading_nxt;
         load_done <= load_done_nxt;
         err       <= err_nxt;
      end
   end

   // Frame length capture and write pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_lo  <= 8'd0;
         n_words <= 16'd0;
         wr_cnt  <= '0;
      end else begin
         if (rx_valid && (state == LEN_LO)) len_lo  <= rx_byte;
         if (rx_valid && (state == LEN_HI)) n_words <= len_c;
         if (frame_start_c || abort_c)      wr_cnt  <= '0;
         else if (pk_valid)                 wr_cnt  <= wr_cnt + CNT_W'(1);
      end
   end

   // Inter-byte idle counter; saturates at the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                tmo_cnt <= '0;
      else if (rx_valid || (state_nxt != state)) tmo_cnt <= '0;
      else if (!tmo_hit_c)                       tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              csum <= 8'd0;
      else if (frame_start_c) csum <= 8'd0;
      else if (data_byte_c)   csum <= csum ^ rx_byte;
   end
`endif

   assign rom_we       = pk_valid;
   assign rom_wdata    = pk_word;
   assign rom_addr     = (state == RUN) ? cpu_rom_addr : wr_cnt[ADDR_W-1:0];
   assign cpu_rom_data = (state == RUN) ? rom_rdata : 32'd0;

endmodule : rom_loader_arb

// File: tb/tb_rom_loader_arb.sv
// Self-checking bench for rom_loader_arb with a ROM model and frame-level
// reference model. Honours LOADER_CHECKSUM_EN.
module tb_rom_loader_arb;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned TMO    = 64;
   localparam int unsigned WORDS  = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte = 8'd0;
   logic [ADDR_W-1:0] cpu_rom_addr = '0;
   logic [31:0]       cpu_rom_data;
   logic              cpu_reset;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_rdata;
   logic              rom_we;
   logic [31:0]       rom_wdata;
   logic              loading;
   logic              load_done;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:WORDS-1];
   logic [7:0]  data_q [$];
   int          wa_q [$];
   logic [31:0] wd_q [$];
   int          ld_cnt  = 0;
   int          ovl_cnt = 0;

   rom_loader_arb #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .cpu_rom_addr (cpu_rom_addr),
      .cpu_rom_data (cpu_rom_data),
      .cpu_reset    (cpu_reset),
      .rom_addr     (rom_addr),
      .rom_rdata    (rom_rdata),
      .rom_we       (rom_we),
      .rom_wdata    (rom_wdata),
      .loading      (loading),
      .load_done    (load_done),
      .err          (err)
   );

   always #5 clk = ~clk;

   // ROM model: contents survive resets, unwritten words hold a known pattern.
   assign rom_rdata = mem[rom_addr];
   always @(posedge clk) if (rom_we) mem[rom_addr] = rom_wdata;

   function automatic logic [31:0] pattern(input int a);
      return 32'hC0DE0000 | 32'(a);
   endfunction

   always @(negedge clk) begin
      if (rom_we) begin
         wa_q.push_back(int'(rom_addr));
         wd_q.push_back(rom_wdata);
      end
      if (load_done) ld_cnt++;
      if (load_done && rom_we) ovl_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   // Reset asserted between clock edges; outputs must clear without a clock.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
      check_eq({tag, ".rom_we"},    32'(rom_we),    32'd0);
      check_eq({tag, ".rom_wdata"}, rom_wdata,      32'd0);
      check_eq({tag, ".loading"},   32'(loading),   32'd0);
      check_eq({tag, ".load_done"}, 32'(load_done), 32'd0);
      check_eq({tag, ".err"},       32'(err),       32'd0);
      check_eq({tag, ".rom_addr"},  32'(rom_addr),  32'd0);
      check_eq({tag, ".cpu_data"},  cpu_rom_data,   32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Sends A5, little-endian word count, the data bytes and (if enabled) the XOR.
   task automatic send_load();
      int n;
      logic [7:0] x;
      n = data_q.size() / 4;
      x = 8'd0;
      send_byte(8'hA5);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      foreach (data_q[i]) begin
         send_byte(data_q[i]);
         x = x ^ data_q[i];
      end
`ifdef LOADER_CHECKSUM_EN
      if (n > 0) send_byte(x);
`endif
      repeat (8) @(negedge clk);
   endtask

   // Expected result of a good frame: word i at address i, one load_done, CPU running.
   task automatic check_load(input string tag, input int wbase, input int ldbase);
      int n;
      logic [31:0] w;
      n = data_q.size() / 4;
      check_eq({tag, ".nwrites"}, 32'(wa_q.size() - wbase), 32'(n));
      for (int i = 0; i < n; i++) begin
         w = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
         if (wbase + i < wa_q.size()) begin
            check_eq($sformatf("%s.waddr%0d", tag, i), 32'(wa_q[wbase+i]), 32'(i));
            check_eq($sformatf("%s.wdata%0d", tag, i), wd_q[wbase+i], w);
         end
         @(negedge clk);
         cpu_rom_addr = ADDR_W'(i);
         #1;
         check_eq($sformatf("%s.fetch%0d", tag, i), cpu_rom_data, w);
      end
      check_eq({tag, ".load_done"}, 32'(ld_cnt - ldbase), 32'd1);
      check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd0);
      check_eq({tag, ".err"},       32'(err),       32'd0);
      check_eq({tag, ".overlap"},   32'(ovl_cnt),   32'd0);
   endtask

   initial begin
      int wb, lb, a;
      logic [7:0] g;
      for (int i = 0; i < int'(WORDS); i++) mem[i] = pattern(i);

      // Directed two-word load
      do_reset("rst0");
      wb = wa_q.size(); lb = ld_cnt;
      data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_load();
      check_load("two_word", wb, lb);
      @(negedge clk);
      cpu_rom_addr = ADDR_W'(1);
      #1 check_eq("fetch_addr1", cpu_rom_data, 32'h88776655);

      // Skip magic: DONE the very next cycle, ROM untouched
      do_reset("rst_skip");
      wb = wa_q.size(); lb = ld_cnt;
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = 8'h5A;
      @(negedge clk);
      rx_valid = 1'b0;
      check_eq("skip.load_done", 32'(load_done), 32'd1);
      check_eq("skip.cpu_reset", 32'(cpu_reset), 32'd0);
      @(negedge clk);
      check_eq("skip.load_done_off", 32'(load_done), 32'd0);
      a = int'($urandom_range(8, WORDS - 1));
      cpu_rom_addr = ADDR_W'(a);
      #1 check_eq("skip.fetch", cpu_rom_data, pattern(a));
      send_byte(8'hA5);
      repeat (4) @(negedge clk);
      check_eq("skip.nwrites", 32'(wa_q.size() - wb), 32'd0);
      check_eq("skip.run_ignores_rx", 32'(loading), 32'd0);

      // Oversized length (2049 words) then recovery with an empty frame
      do_reset("rst_ovf");
      lb = ld_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h08);
      repeat (3) @(negedge clk);
      check_eq("ovf.err", 32'(err), 32'd1);
      check_eq("ovf.cpu_reset", 32'(cpu_reset), 32'd1);
      check_eq("ovf.loading", 32'(loading), 32'd0);
      send_byte(8'h33);
      check_eq("ovf.err_held", 32'(err), 32'd1);
      send_byte(8'hA5);
      check_eq("ovf.restart_err", 32'(err), 32'd0);
      check_eq("ovf.restart_loading", 32'(loading), 32'd1);
      send_byte(8'h00); send_byte(8'h00);
      repeat (4) @(negedge clk);
      check_eq("ovf.cpu_reset_rel", 32'(cpu_reset), 32'd0);
      check_eq("ovf.load_done", 32'(ld_cnt - lb), 32'd1);

      // Inter-byte timeout aborts the frame back to idle
      do_reset("rst_tmo");
      wb = wa_q.size(); lb = ld_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      check_eq("tmo.loading_before", 32'(loading), 32'd1);
      repeat (TMO + 4) @(negedge clk);
      check_eq("tmo.loading", 32'(loading), 32'd0);
      check_eq("tmo.err", 32'(err), 32'd0);
      check_eq("tmo.cpu_reset", 32'(cpu_reset), 32'd1);
      check_eq("tmo.nwrites", 32'(wa_q.size() - wb), 32'd0);
      send_byte(8'h5A);
      repeat (2) @(negedge clk);
      check_eq("tmo.idle_skip", 32'(ld_cnt - lb), 32'd1);

      // Reset in the middle of a data word, then a clean load from address 0
      do_reset("rst_mid0");
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      check_eq("mid.loading", 32'(loading), 32'd1);
      do_reset("rst_mid");
      wb = wa_q.size(); lb = ld_cnt;
      data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_load();
      check_load("mid_reload", wb, lb);

`ifdef LOADER_CHECKSUM_EN
      do_reset("rst_cs_ok");
      lb = ld_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0F);
      repeat (3) @(negedge clk);
      check_eq("cs_ok.load_done", 32'(ld_cnt - lb), 32'd1);
      check_eq("cs_ok.err", 32'(err), 32'd0);
      do_reset("rst_cs_bad");
      lb = ld_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h00);
      repeat (3) @(negedge clk);
      check_eq("cs_bad.err", 32'(err), 32'd1);
      check_eq("cs_bad.cpu_reset", 32'(cpu_reset), 32'd1);
      check_eq("cs_bad.load_done", 32'(ld_cnt - lb), 32'd0);
`endif

      // Random frames preceded by random noise bytes in idle
      for (int it = 0; it < 8; it++) begin
         do_reset($sformatf("rst_rnd%0d", it));
         wb = wa_q.size(); lb = ld_cnt;
         repeat ($urandom_range(0, 3)) begin
            do g = 8'($urandom); while (g == 8'hA5 || g == 8'h5A);
            send_byte(g);
         end
         data_q.delete();
         repeat (4 * $urandom_range(1, 6)) data_q.push_back(8'($urandom));
         send_load();
         check_load($sformatf("rnd%0d", it), wb, lb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule : tb_rom_loader_arb
